// File: rtl/hzu_scoreboard_if.sv
// Issue-side bundle for hzu_scoreboard, plus the decoded-instruction types it carries.
// The optional macro HZU_BYPASS_EN affects only hzu_scoreboard, not this bundle.
package hzu_pkg;
    typedef enum logic [3:0] {
        OP_NOP      = 4'd0,
        OP_ADD      = 4'd1,
        OP_SUB      = 4'd2,
        OP_MUL      = 4'd3,
        OP_BEQ      = 4'd4,
        OP_TLBWRITE = 4'd5,
        OP_LDB      = 4'd6,
        OP_LDW      = 4'd7,
        OP_STB      = 4'd8,
        OP_STW      = 4'd9,
        OP_MOV      = 4'd10
    } op_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [4:0] src1;
        logic [4:0] src2;
    } rfields_t;

    typedef struct packed {
        logic [4:0] dst;
        logic [9:0] imm;
    } ifields_t;

    typedef union packed {
        rfields_t r;
        ifields_t i;
    } fields_t;

    typedef struct packed {
        op_t     op;
        fields_t fields;
    } instr_t;
endpackage

interface hzu_scoreboard_if #(
    parameter int NTHREADS = 4
);
    localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

    logic                 issue_valid;
    logic [TW-1:0]        issue_thread;
    hzu_pkg::instr_t      issue_instr;
    logic                 itlb_miss;
    logic                 icache_miss;
    logic                 freeze;
    logic                 isvalid;
    logic [1:0]           stall_code;
    logic [NTHREADS-1:0]  busy_any;

    modport master (
        output issue_valid, issue_thread, issue_instr, itlb_miss, icache_miss, freeze,
        input  isvalid, stall_code, busy_any
    );

    modport slave (
        input  issue_valid, issue_thread, issue_instr, itlb_miss, icache_miss, freeze,
        output isvalid, stall_code, busy_any
    );
endinterface

// File: rtl/hzu_scoreboard.sv
// Per-thread/per-register countdown scoreboard gating issue, with memory-port store gap.
// Define HZU_BYPASS_EN to treat a source whose counter is 1 as forwarded.
module hzu_scoreboard #(
    parameter int NTHREADS  = 4,
    parameter int NREGS     = 32,
    parameter int ALU_LAT   = 2,
    parameter int MUL_LAT   = 5,
    parameter int MEM_LAT   = 3,
    parameter int STORE_GAP = 1
) (
    input logic               clk,
    input logic               rst,
    hzu_scoreboard_if.slave   bus
);
    localparam int RW      = $clog2(NREGS);
    localparam int LAT_A   = (MUL_LAT > MEM_LAT) ? MUL_LAT : MEM_LAT;
    localparam int MAX_LAT = (LAT_A > ALU_LAT) ? LAT_A : ALU_LAT;
    localparam int CW      = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int GW      = (STORE_GAP > 0) ? $clog2(STORE_GAP + 1) : 1;

    // Opcode encodings mirror hzu_pkg::op_t.
    localparam logic [3:0] OPC_ADD      = 4'd1;
    localparam logic [3:0] OPC_SUB      = 4'd2;
    localparam logic [3:0] OPC_MUL      = 4'd3;
    localparam logic [3:0] OPC_BEQ      = 4'd4;
    localparam logic [3:0] OPC_TLBWRITE = 4'd5;
    localparam logic [3:0] OPC_LDB      = 4'd6;
    localparam logic [3:0] OPC_LDW      = 4'd7;
    localparam logic [3:0] OPC_STB      = 4'd8;
    localparam logic [3:0] OPC_STW      = 4'd9;
    localparam logic [3:0] OPC_MOV      = 4'd10;

`ifdef HZU_BYPASS_EN
    localparam logic [CW-1:0] HAZ_TH = CW'(1);
`else
    localparam logic [CW-1:0] HAZ_TH = CW'(0);
`endif

    logic [CW-1:0]       cnt_r      [NTHREADS][NREGS];
    logic [CW-1:0]       cnt_next_s [NTHREADS][NREGS];
    logic [GW-1:0]       mem_busy_r;
    logic [GW-1:0]       mem_next_s;
    logic [NTHREADS-1:0] busy_any_r;
    logic [NTHREADS-1:0] busy_next_s;

    logic [3:0]    op_s;
    logic          has_src2_s;
    logic          has_dst_s;
    logic          is_mem_s;
    logic          is_store_s;
    logic [CW-1:0] lat_s;
    logic [RW-1:0] src1_s;
    logic [RW-1:0] src2_s;
    logic [RW-1:0] dst_s;
    logic          data_haz_s;
    logic          struct_haz_s;
    logic          isvalid_s;
    logic [1:0]    stall_code_s;

    // Classify the presented op: operand usage, memory-port use and busy latency.
    always_comb begin
        op_s       = bus.issue_instr.op;
        has_src2_s = 1'b0;
        has_dst_s  = 1'b0;
        is_mem_s   = 1'b0;
        is_store_s = 1'b0;
        lat_s      = CW'(0);
        case (op_s)
            OPC_ADD, OPC_SUB: begin
                has_src2_s = 1'b1;
                has_dst_s  = 1'b1;
                lat_s      = CW'(ALU_LAT);
            end
            OPC_MUL: begin
                has_src2_s = 1'b1;
                has_dst_s  = 1'b1;
                lat_s      = CW'(MUL_LAT);
            end
            OPC_BEQ, OPC_TLBWRITE: begin
                has_src2_s = 1'b1;
            end
            OPC_LDB, OPC_LDW: begin
                has_dst_s = 1'b1;
                is_mem_s  = 1'b1;
                lat_s     = CW'(MEM_LAT);
            end
            OPC_STB, OPC_STW: begin
                is_mem_s   = 1'b1;
                is_store_s = 1'b1;
            end
            OPC_MOV: begin
                has_dst_s = 1'b1;
                lat_s     = CW'(ALU_LAT);
            end
            default: begin
                has_dst_s = 1'b0;
            end
        endcase
    end

    // Zero-latency accept decision and rejection reason.
    always_comb begin
        src1_s       = bus.issue_instr.fields.r.src1[RW-1:0];
        src2_s       = bus.issue_instr.fields.r.src2[RW-1:0];
        dst_s        = bus.issue_instr.fields.r.dst[RW-1:0];
        data_haz_s   = (cnt_r[bus.issue_thread][src1_s] > HAZ_TH) ||
                       (has_src2_s && (cnt_r[bus.issue_thread][src2_s] > HAZ_TH));
        struct_haz_s = is_mem_s && (mem_busy_r != GW'(0));
        isvalid_s    = 1'b0;
        stall_code_s = 2'd0;
        if (rst || bus.freeze || !bus.issue_valid) begin
            stall_code_s = 2'd0;
        end else if (bus.itlb_miss || bus.icache_miss) begin
            stall_code_s = 2'd1;
        end else if (data_haz_s) begin
            stall_code_s = 2'd2;
        end else if (struct_haz_s) begin
            stall_code_s = 2'd3;
        end else begin
            isvalid_s = 1'b1;
        end
    end

    // Next-state counters: decrement everything, then an accepted op's load wins.
    always_comb begin
        cnt_next_s = cnt_r;
        mem_next_s = mem_busy_r;
        if (!bus.freeze) begin
            for (int t = 0; t < NTHREADS; t++) begin
                for (int r = 0; r < NREGS; r++) begin
                    if (cnt_r[t][r] != CW'(0)) begin
                        cnt_next_s[t][r] = cnt_r[t][r] - CW'(1);
                    end else begin
                        cnt_next_s[t][r] = CW'(0);
                    end
                end
            end
            if (mem_busy_r != GW'(0)) begin
                mem_next_s = mem_busy_r - GW'(1);
            end else begin
                mem_next_s = GW'(0);
            end
            if (isvalid_s && has_dst_s) begin
                cnt_next_s[bus.issue_thread][dst_s] = lat_s;
            end else begin
                cnt_next_s[bus.issue_thread][dst_s] = cnt_next_s[bus.issue_thread][dst_s];
            end
            if (isvalid_s && is_store_s) begin
                mem_next_s = GW'(STORE_GAP);
            end else begin
                mem_next_s = mem_next_s;
            end
        end else begin
            mem_next_s = mem_busy_r;
        end
    end

    // Per-thread OR of the next-state counters.
    always_comb begin
        busy_next_s = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            for (int r = 0; r < NREGS; r++) begin
                busy_next_s[t] = busy_next_s[t] | (cnt_next_s[t][r] != CW'(0));
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '{default: '0};
            mem_busy_r <= GW'(0);
            busy_any_r <= '0;
        end else begin
            cnt_r      <= cnt_next_s;
            mem_busy_r <= mem_next_s;
            busy_any_r <= busy_next_s;
        end
    end

    assign bus.isvalid    = isvalid_s;
    assign bus.stall_code = stall_code_s;
    assign bus.busy_any   = busy_any_r;
endmodule

// File: tb/tb_hzu_scoreboard.sv
// Scoreboard bench for hzu_scoreboard: directed steps queue expectations, a negedge monitor checks them.
module tb_hzu_scoreboard;
    import hzu_pkg::*;

`ifdef HZU_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    typedef struct {
        string      name;
        logic       v;
        logic [1:0] code;
        bit         chk_busy;
        logic [3:0] busy;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    hzu_scoreboard_if #(.NTHREADS(4)) bus ();

    hzu_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t mk(input op_t op, input int dst, input int s1, input int s2);
        instr_t i;
        i.op             = op;
        i.fields.r.dst   = 5'(dst);
        i.fields.r.src1  = 5'(s1);
        i.fields.r.src2  = 5'(s2);
        return i;
    endfunction

    // One cycle: drive inputs, queue the expected response, advance past the edge.
    task automatic step(input string nm, input logic r, input logic v, input logic [1:0] th,
                        input instr_t ins, input logic im, input logic tm, input logic fz,
                        input logic ev, input logic [1:0] ec, input bit cb, input logic [3:0] eb);
        exp_t e;
        rst              = r;
        bus.issue_valid  = v;
        bus.issue_thread = th;
        bus.issue_instr  = ins;
        bus.icache_miss  = im;
        bus.itlb_miss    = tm;
        bus.freeze       = fz;
        e.name = nm; e.v = ev; e.code = ec; e.chk_busy = cb; e.busy = eb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic iss(input string nm, input logic [1:0] th, input instr_t ins,
                       input logic ev, input logic [1:0] ec);
        step(nm, 1'b0, 1'b1, th, ins, 1'b0, 1'b0, 1'b0, ev, ec, 1'b0, 4'd0);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 7; i++) begin
            step(nm, 1'b0, 1'b0, 2'd0, mk(OP_NOP, 0, 0, 0), 1'b0, 1'b0, 1'b0,
                 1'b0, 2'd0, (i == 6), 4'd0);
        end
    endtask

    // RAW on r3 produced by op with busy latency lat; dependent add r4=r3+r1 held from cycle 1.
    task automatic raw_test(input string nm, input op_t prod, input int lat);
        int acc;
        acc = lat + 1 - BYP;
        iss({nm, "_prod"}, 2'd0, mk(prod, 3, 1, 2), 1'b1, 2'd0);
        for (int k = 1; k <= lat + 1; k++) begin
            if (k >= acc) iss({nm, "_dep"}, 2'd0, mk(OP_ADD, 4, 3, 1), 1'b1, 2'd0);
            else          iss({nm, "_dep"}, 2'd0, mk(OP_ADD, 4, 3, 1), 1'b0, 2'd2);
        end
        drain({nm, "_drain"});
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.isvalid !== e.v) begin
                    failures++;
                    $display("FAIL %s isvalid got=%b exp=%b t=%0t", e.name, bus.isvalid, e.v, $time);
                end
                checks++;
                if (bus.stall_code !== e.code) begin
                    failures++;
                    $display("FAIL %s stall_code got=%0d exp=%0d t=%0t", e.name, bus.stall_code, e.code, $time);
                end
                if (e.chk_busy) begin
                    checks++;
                    if (bus.busy_any !== e.busy) begin
                        failures++;
                        $display("FAIL %s busy_any got=%b exp=%b t=%0t", e.name, bus.busy_any, e.busy, $time);
                    end
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_thread = 2'd0; bus.issue_instr = mk(OP_NOP, 0, 0, 0);
        bus.icache_miss = 1'b0; bus.itlb_miss = 1'b0; bus.freeze = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a valid instruction presented, then first issue.
        for (int i = 0; i < 2; i++)
            step("rst_hold", 1'b1, 1'b1, 2'd0, mk(OP_ADD, 1, 2, 3), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd0);
        step("first_add", 1'b0, 1'b1, 2'd0, mk(OP_ADD, 1, 2, 3), 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0);
        drain("first_drain");

        // RAW timing for each latency class.
        raw_test("raw_mul", OP_MUL, 5);
        raw_test("raw_alu", OP_ADD, 2);
        raw_test("raw_ldw", OP_LDW, 3);

        // Thread isolation and src2-less op reading a busy register.
        iss("iso_mul", 2'd0, mk(OP_MUL, 3, 1, 2), 1'b1, 2'd0);
        step("iso_add_t1", 1'b0, 1'b1, 2'd1, mk(OP_ADD, 4, 3, 1), 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001);
        step("iso_busy", 1'b0, 1'b0, 2'd0, mk(OP_NOP, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0011);
        iss("mov_src2_ignored", 2'd0, mk(OP_MOV, 5, 1, 3), 1'b1, 2'd0);
        drain("iso_drain");

        // Store gap: memory ops blocked for one cycle after a store, ALU ops unaffected.
        iss("gap_stw", 2'd0, mk(OP_STW, 0, 1, 2), 1'b1, 2'd0);
        iss("gap_ldw_rej", 2'd2, mk(OP_LDW, 5, 6, 0), 1'b0, 2'd3);
        iss("gap_ldw_acc", 2'd2, mk(OP_LDW, 5, 6, 0), 1'b1, 2'd0);
        drain("gap_drain1");
        iss("gap_stw2", 2'd0, mk(OP_STW, 0, 1, 2), 1'b1, 2'd0);
        iss("gap_add_t2", 2'd2, mk(OP_ADD, 7, 8, 9), 1'b1, 2'd0);
        drain("gap_drain2");
        iss("gap_stb_a", 2'd1, mk(OP_STB, 0, 1, 2), 1'b1, 2'd0);
        iss("gap_stb_b", 2'd3, mk(OP_STB, 0, 1, 2), 1'b0, 2'd3);
        drain("gap_drain3");

        // Priority: fetch miss over data hazard, data hazard over structural.
        iss("pri_mul", 2'd0, mk(OP_MUL, 3, 1, 2), 1'b1, 2'd0);
        step("pri_icache", 1'b0, 1'b1, 2'd0, mk(OP_ADD, 4, 3, 1), 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd0);
        step("pri_itlb", 1'b0, 1'b1, 2'd0, mk(OP_ADD, 4, 3, 1), 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'd0);
        iss("pri_stw_t1", 2'd1, mk(OP_STW, 0, 1, 2), 1'b1, 2'd0);
        iss("pri_data_vs_struct", 2'd0, mk(OP_LDW, 9, 3, 0), 1'b0, 2'd2);
        drain("pri_drain");

        // Freeze for cycles 2..4 during the mul RAW case.
        iss("frz_mul", 2'd0, mk(OP_MUL, 3, 1, 2), 1'b1, 2'd0);
        for (int k = 1; k <= 9; k++) begin
            if (k >= 2 && k <= 4)
                step("frz_hold", 1'b0, 1'b1, 2'd0, mk(OP_ADD, 4, 3, 1), 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, (k == 3), 4'b0001);
            else if (k >= 9 - BYP)
                iss("frz_dep", 2'd0, mk(OP_ADD, 4, 3, 1), 1'b1, 2'd0);
            else
                iss("frz_dep", 2'd0, mk(OP_ADD, 4, 3, 1), 1'b0, 2'd2);
        end
        drain("frz_drain");

        // Reset mid-operation clears pending hazards.
        iss("mrst_mul", 2'd0, mk(OP_MUL, 3, 1, 2), 1'b1, 2'd0);
        iss("mrst_dep", 2'd0, mk(OP_ADD, 4, 3, 1), 1'b0, 2'd2);
        step("mrst_rst", 1'b1, 1'b1, 2'd0, mk(OP_ADD, 4, 3, 1), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0);
        step("mrst_after", 1'b0, 1'b1, 2'd0, mk(OP_ADD, 4, 3, 1), 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0);
        step("mrst_idle", 1'b0, 1'b0, 2'd0, mk(OP_NOP, 0, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0001);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL monitor_drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
